// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the fetch PC, keeps at most one imem request
//   outstanding and presents {pc, instr} to decode through a one-entry valid/ready register.
// Latency: id_valid rises the cycle after the imem response; 2 cycles/instr at 1-cycle imem latency.
// Backpressure: a request issues only if the output slot is empty or drains that cycle
//   (imem_req_valid is combinational on id_ready); imem responses are never stalled.
// Ports: clk, reset (async, active-high); redirect_valid/redirect_pc from execute;
//   imem_req_valid/addr/ready and imem_rsp_valid/data to instruction memory;
//   id_valid/id_pc/id_instr/id_ready to decode; pc_out is the current fetch PC.
// Optional macro FETCH_MISALIGN_CHECK_EN: adds output fetch_misaligned and state S_FAULT that
//   parks fetch on a misaligned redirect target; without it redirect_pc[1:0] is forced to 0.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  input  logic        id_ready,
  output logic [31:0] pc_out
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        fetch_misaligned
`endif
);

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DROP, S_FAULT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;
`endif

  state_t      state;
  state_t      state_nxt;
  logic [31:0] req_pc;        // PC of the request currently outstanding
  logic        redir;         // redirect honoured this cycle (ignored while in S_IDLE)
  logic        req_fire;
  logic        rsp_load;      // response lands in the output slot
  logic [31:0] redir_target;

  assign redir         = redirect_valid && (state != S_IDLE);
  assign req_fire      = imem_req_valid && imem_req_ready;
  assign imem_req_addr = pc_out;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misaligned;
  logic rsp_owed;       // S_FAULT only: imem still owes a response that must be dropped
  logic rsp_owed_nxt;
  logic owed_now;       // a response is still owed after this cycle

  assign misaligned   = redir && (redirect_pc[1:0] != 2'b00);
  assign redir_target = redirect_pc;
  assign owed_now     = !imem_rsp_valid &&
                        ((state == S_WAIT) || (state == S_DROP) || ((state == S_FAULT) && rsp_owed));
`else
  assign redir_target = redirect_pc & ~32'h0000_0003;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
`ifdef FETCH_MISALIGN_CHECK_EN
      rsp_owed <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
`ifdef FETCH_MISALIGN_CHECK_EN
      rsp_owed <= rsp_owed_nxt;
`endif
    end
  end

  // Next state and request/load strobes
  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    rsp_load       = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    rsp_owed_nxt   = rsp_owed;
`endif
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        // Never request into a slot that will still be occupied next cycle.
        imem_req_valid = !redirect_valid && (!id_valid || id_ready);
        if (!redirect_valid && (!id_valid || id_ready) && imem_req_ready)
          state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          rsp_load  = !redirect_valid;  // a same-cycle redirect kills this response
          state_nxt = S_REQ;
        end else if (redirect_valid) begin
          state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rsp_valid)
          state_nxt = S_REQ;
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      S_FAULT: begin
        if (imem_rsp_valid)
          rsp_owed_nxt = 1'b0;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
`ifdef FETCH_MISALIGN_CHECK_EN
    if (misaligned) begin
      state_nxt    = S_FAULT;
      rsp_owed_nxt = owed_now;
    end else if (redir && (state == S_FAULT)) begin
      state_nxt    = owed_now ? S_DROP : S_REQ;
      rsp_owed_nxt = 1'b0;
    end
`endif
  end

  // Fetch PC, outstanding-request PC and decode output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_out   <= RESET_PC;
      req_pc   <= 32'h0;
      id_valid <= 1'b0;
      id_pc    <= 32'h0;
      id_instr <= 32'h0;
    end else begin
      if (redir) begin
        pc_out <= redir_target;
      end else if (req_fire) begin
        req_pc <= pc_out;
        pc_out <= pc_out + 32'd4;
      end

      if (redir) begin
        id_valid <= 1'b0;
      end else if (rsp_load) begin
        id_valid <= 1'b1;
        id_pc    <= req_pc;
        id_instr <= imem_rsp_data;
      end else if (id_ready) begin
        id_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      fetch_misaligned <= 1'b0;
    else if (misaligned)
      fetch_misaligned <= 1'b1;
    else if (redir)
      fetch_misaligned <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with an imem model of programmable latency
//   and a scoreboard of expected {pc, instr} pushed at request acceptance, popped at decode handshake.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_ready;
  logic [31:0] pc_out;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_misaligned;
`endif

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
    .id_ready       (id_ready),
    .pc_out         (pc_out)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_req = 0;
  int          n_out = 0;
  int          last_out_cyc = 0;
  int          prev_out_cyc = 0;
  int          n_req0;
  int          n_out0;
  logic [31:0] last_req = 32'h0;
  logic [31:0] last_id_pc = 32'h0;
  logic [31:0] exp_pc = 32'h0;
  bit          mem_pend = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_cnt = 0;
  int          mem_lat = 1;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic step();
    exp_t e;
    exp_t e_new;
    if (mem_pend && mem_cnt == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(mem_addr);
      mem_pend       = 1'b0;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
      if (mem_pend) mem_cnt--;
    end
    #1;
    if (redirect_valid) begin
      chk("no_req_on_redirect", {31'b0, imem_req_valid}, 32'd0);
      sb.delete();
      exp_pc = redirect_pc & ~32'h0000_0003;
    end else if (id_valid && id_ready) begin
      chk("out_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("id_pc", id_pc, e.pc);
        chk("id_instr", id_instr, e.instr);
      end
      n_out++;
      prev_out_cyc = last_out_cyc;
      last_out_cyc = cyc;
      last_id_pc   = id_pc;
    end
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, exp_pc);
      mem_pend = 1'b1;
      mem_addr = imem_req_addr;
      mem_cnt  = mem_lat - 1;
      e_new.pc    = exp_pc;
      e_new.instr = memf(exp_pc);
      sb.push_back(e_new);
      exp_pc   = exp_pc + 32'd4;
      n_req++;
      last_req = imem_req_addr;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_out(input int max, input string tag);
    int start;
    int k;
    start = n_out;
    k = 0;
    while (n_out == start && k < max) begin
      step();
      k++;
    end
    chk(tag, 32'(n_out - start), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;          // a response during reset must be ignored
    imem_rsp_data  = 32'hBAD0_BAD0;
    id_ready       = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_instr", id_instr, 32'h0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("rst_misaligned", {31'b0, fetch_misaligned}, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    cyc   = 0;

    // Streaming: idle, req, rsp, first output at cycle 3 then every 2nd cycle
    wait_out(10, "t1_out0");
    chk("t1_first_cyc", 32'(last_out_cyc), 32'd3);
    chk("t1_pc0", last_id_pc, 32'h0);
    wait_out(10, "t1_out1");
    chk("t1_gap1", 32'(last_out_cyc - prev_out_cyc), 32'd2);
    chk("t1_pc1", last_id_pc, 32'h4);
    wait_out(10, "t1_out2");
    chk("t1_gap2", 32'(last_out_cyc - prev_out_cyc), 32'd2);
    chk("t1_pc2", last_id_pc, 32'h8);

    // Decode stall: slot full, no request, output stable
    id_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_id_valid", {31'b0, id_valid}, 32'd1);
      chk("t2_no_req", {31'b0, imem_req_valid}, 32'd0);
      chk("t2_id_pc", id_pc, 32'hC);
      chk("t2_id_instr", id_instr, memf(32'hC));
      step();
    end
    id_ready = 1'b1;
    mem_lat  = 3;
    #1;
    chk("t2_req_same_cycle", {31'b0, imem_req_valid}, 32'd1);
    chk("t2_req_addr", imem_req_addr, 32'h10);
    step();

    // Redirect in S_WAIT, stale response arrives 3 cycles after acceptance
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_valid = 1'b0;
    mem_lat        = 1;
    n_req0         = n_req;
    n_out0         = n_out;
    step();
    step();
    chk("t3_no_req_drop", 32'(n_req - n_req0), 32'd0);
    chk("t3_no_out_drop", 32'(n_out - n_out0), 32'd0);
    step();
    chk("t3_one_req", 32'(n_req - n_req0), 32'd1);
    chk("t3_req_addr", last_req, 32'h100);
    wait_out(10, "t3_out");
    chk("t3_id_pc", last_id_pc, 32'h100);

    // Redirect coinciding with the response
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    n_out0         = n_out;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t4_id_valid", {31'b0, id_valid}, 32'd0);
    chk("t4_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t4_req_addr", imem_req_addr, 32'h200);
    wait_out(10, "t4_out");
    chk("t4_no_stale_out", 32'(n_out - n_out0), 32'd1);
    chk("t4_id_pc", last_id_pc, 32'h200);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    chk("t5_req_top", last_req, 32'hFFFF_FFFC);
    wait_out(10, "t5_out_top");
    chk("t5_id_top", last_id_pc, 32'hFFFF_FFFC);
    chk("t5_req_wrap", last_req, 32'h0);
    wait_out(10, "t5_out_wrap");
    chk("t5_id_wrap", last_id_pc, 32'h0);

    // Misaligned redirect target
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    #1;
    chk("t6_misaligned", {31'b0, fetch_misaligned}, 32'd1);
    chk("t6_pc_unmasked", pc_out, 32'h102);
    n_req0 = n_req;
    repeat (4) step();
    chk("t6_no_req_fault", 32'(n_req - n_req0), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t6_misaligned_clr", {31'b0, fetch_misaligned}, 32'd0);
    step();
    chk("t6_req_aligned", last_req, 32'h300);
    wait_out(10, "t6_out");
    chk("t6_id_pc", last_id_pc, 32'h300);
`else
    step();
    chk("t6_req_masked", last_req, 32'h100);
    wait_out(10, "t6_out");
    chk("t6_id_pc", last_id_pc, 32'h100);
`endif

    // Asynchronous reset mid-operation
    reset = 1'b1;
    #1;
    chk("t7_pc_out", pc_out, 32'h0);
    chk("t7_id_valid", {31'b0, id_valid}, 32'd0);
    chk("t7_id_pc", id_pc, 32'h0);
    chk("t7_req_valid", {31'b0, imem_req_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
